data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL provide parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 The block SHALL provide parameter LATENCY, default 2, meaning the cycles from request acceptance to response valid; legal range 1..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_funct3  input  3  RV32I load/store width code
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  load result, extended per funct3
- rsp_err  output  1  request rejected

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP, with one transaction outstanding at most.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-006 On acceptance, the block SHALL register we, addr, wdata and funct3, then move to WAIT with counter=LATENCY-1, or directly to RESP if LATENCY=1.
REQ-007 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter equals 1; rsp_valid SHALL therefore first be high exactly LATENCY cycles after the acceptance cycle.
REQ-008 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until a rising edge with rsp_ready=1, which returns the FSM to IDLE.
REQ-009 A request SHALL NOT be accepted in the same cycle a response completes; req_ready rises the cycle after.
REQ-010 Legal funct3 values SHALL be:
- loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- stores: 000 sb, 001 sh, 010 sw
All other codes SHALL set rsp_err=1.
REQ-011 rsp_err SHALL be 1 when any of the following holds:
- halfword access with addr[0]!=0
- word access with addr[1:0]!=0
- addr >= 4*DEPTH_WORDS
- illegal funct3
REQ-012 Storage SHALL be little-endian; word index = addr[31:2], byte lane = addr[1:0].
REQ-013 An error-free store SHALL update only the addressed byte lanes, using the low bits of req_wdata, on the acceptance edge.
REQ-014 An erroneous store SHALL leave memory unchanged.
REQ-015 For a load, rsp_rdata SHALL be read from memory after the acceptance edge, then extended:
- lb, lh: sign-extended
- lbu, lhu: zero-extended
- lw: unchanged
REQ-016 For a store, and for any error response, rsp_rdata SHALL be 0x00000000.
REQ-017 req_ready SHALL ignore rsp_ready and all request inputs while not in IDLE.

Reset
REQ-018 While reset=1, the block SHALL asynchronously drive:
- state=IDLE, counter=0
- req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0
REQ-019 req_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-020 Reset during WAIT or RESP SHALL discard the transaction with no response; a store already committed at acceptance SHALL remain committed.
REQ-021 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-022 With LATENCY=2, sw 0xDEADBEEF to 0x10, then lw 0x10 -> each rsp_valid is high 2 cycles after acceptance; the load returns rdata=0xDEADBEEF, err=0.
REQ-023 Following REQ-022: lb 0x11 -> 0xFFFFFFBE; lbu 0x11 -> 0x000000BE; lh 0x12 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000DEAD.
REQ-024 sh to 0x13, sw to 0x12, and lw to 4*DEPTH_WORDS -> each gives err=1, rdata=0; a subsequent lw 0x10 still returns 0xDEADBEEF.
REQ-025 sb 0xA5 to 0x10 -> lw 0x10 returns 0xDEADBEA5.
REQ-026 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0; raising rsp_ready completes the response, and req_ready=1 the following cycle.
REQ-027 Assert reset mid-WAIT -> outputs go to 0 immediately with no clock edge, and no response ever appears; req_ready=1 the cycle after release.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory responder for an RV32I-style core: one transaction in flight,
// fixed LATENCY from acceptance to response, little-endian byte/half/word access.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state | meaning
    // IDLE  | req_ready high, waiting for a request
    // WAIT  | request latched, counting down the access latency
    // RESP  | response presented, held until rsp_ready

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               we_q;
    logic [2:0]         f3_q;
    logic [1:0]         lane_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;

    logic               accept;
    logic               err_in;
    logic [IDX_W-1:0]   req_idx;

    function automatic logic access_err(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr);
        logic bad_f3;
        logic misal;
        logic out_of_range;
        bad_f3       = 1'b0;
        misal        = 1'b0;
        out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
        case (f3)
            3'b000:         misal = 1'b0;
            3'b001:         misal = addr[0];
            3'b010:         misal = |addr[1:0];
            3'b100, 3'b101: begin
                bad_f3 = we;
                misal  = f3[0] & addr[0];
            end
            default:        bad_f3 = 1'b1;
        endcase
        return bad_f3 | misal | out_of_range;
    endfunction

    function automatic logic [31:0] resp_word(input logic        we,
                                              input logic        err,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = 32'b0;
        endcase
        return (we | err) ? 32'b0 : r;
    endfunction

    assign accept  = req_valid & req_ready;
    assign err_in  = access_err(req_we, req_funct3, req_addr);
    assign req_idx = req_addr[IDX_W+1:2];

    // Stores commit on the acceptance edge; reset never touches the array.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err_in) begin
            case (req_funct3)
                3'b000:  mem[req_idx][{req_addr[1:0], 3'b000} +: 8]   <= req_wdata[7:0];
                3'b001:  mem[req_idx][{req_addr[1], 4'b0000} +: 16]   <= req_wdata[15:0];
                default: mem[req_idx]                                 <= req_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b0;
            lane_q    <= 2'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        idx_q     <= req_idx;
                        err_q     <= err_in;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err_in;
                            rsp_rdata <= resp_word(req_we, err_in, req_funct3,
                                                   req_addr[1:0], mem[req_idx]);
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        cnt       <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= resp_word(we_q, err_q, f3_q, lane_q, mem[idx_q]);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
